// File: rtl/ieee_to_fp_11_9.sv
// IEEE-754 binary32 to FloPoCo (wE=11, wF=9) converter, 2-stage valid/ready pipeline.
// Define IEEE_SUBNORM_EN to normalize subnormal inputs; otherwise they flush to zero.
module ieee_to_fp_11_9 #(
  parameter int WIDTH = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_data,
  output logic [15:0]      conv_count
);

  typedef enum logic [1:0] {
    EXC_ZERO   = 2'b00,
    EXC_NORMAL = 2'b01,
    EXC_INF    = 2'b10,
    EXC_NAN    = 2'b11
  } exc_e;

  logic        in_sign;
  logic [7:0]  in_exp;
  logic [22:0] in_frac;

  logic [22:0] norm_frac;
  logic [10:0] norm_exp;
  logic        round_up;
  logic [9:0]  rnd_frac;
  logic [10:0] rnd_exp;

  exc_e        cls_exc;
  logic        cls_sign;
  logic [10:0] cls_exp;
  logic [8:0]  cls_frac;
  logic [WIDTH:0] cls_word;

  logic           s1_valid_q, s1_valid_d;
  logic [WIDTH:0] s1_word_q,  s1_word_d;
  logic           out_valid_q, out_valid_d;
  logic [WIDTH:0] out_data_q,  out_data_d;
  logic [15:0]    conv_count_q, conv_count_d;

  assign in_sign = in_data[31];
  assign in_exp  = in_data[30:23];
  assign in_frac = in_data[22:0];

`ifdef IEEE_SUBNORM_EN
  logic       is_subnorm;
  logic [4:0] lz;

  // Leading-zero count over the 23-bit fraction; the highest set bit wins.
  function automatic logic [4:0] lzc23(input logic [22:0] v);
    logic [4:0] n;
    n = 5'd23;
    for (int unsigned i = 0; i < 23; i++) begin
      if (v[i]) n = 5'(22 - i);
    end
    return n;
  endfunction

  assign is_subnorm = (in_exp == '0) && (in_frac != '0);
  assign lz         = lzc23(in_frac);
`endif

  // Normalize: rebias the exponent and, for subnormals, shift past the leading one.
  always_comb begin
    norm_frac = in_frac;
    norm_exp  = {3'b000, in_exp} + 11'd896;
`ifdef IEEE_SUBNORM_EN
    if (is_subnorm) begin
      norm_frac = in_frac << (lz + 5'd1);
      norm_exp  = 11'd896 - {6'b000000, lz};
    end
`endif
  end

  // Round to nearest even at bit 14; a carry out bumps the exponent and leaves frac 0.
  always_comb begin
    round_up = norm_frac[13] && ((|norm_frac[12:0]) || norm_frac[14]);
    rnd_frac = {1'b0, norm_frac[22:14]} + {9'b0, round_up};
    rnd_exp  = norm_exp + {10'b0, rnd_frac[9]};
  end

  always_comb begin
    cls_exc  = EXC_ZERO;
    cls_sign = in_sign;
    cls_exp  = '0;
    cls_frac = '0;
    if (in_exp == 8'hFF) begin
      if (in_frac == '0) begin
        cls_exc = EXC_INF;
      end else begin
        cls_exc  = EXC_NAN;
        cls_sign = 1'b0;
      end
    end else if (in_exp != '0) begin
      cls_exc  = EXC_NORMAL;
      cls_exp  = rnd_exp;
      cls_frac = rnd_frac[8:0];
    end
`ifdef IEEE_SUBNORM_EN
    else if (is_subnorm) begin
      cls_exc  = EXC_NORMAL;
      cls_exp  = rnd_exp;
      cls_frac = rnd_frac[8:0];
    end
`endif
  end

  assign cls_word = {cls_exc, cls_sign, cls_exp, cls_frac};

  assign in_ready = !out_valid_q || out_ready;

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_word_d    = s1_word_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    conv_count_d = conv_count_q;
    if (in_ready) begin
      s1_valid_d  = in_valid;
      out_valid_d = s1_valid_q;
      if (in_valid)   s1_word_d  = cls_word;
      if (s1_valid_q) out_data_d = s1_word_q;
    end
    if (out_valid_q && out_ready) conv_count_d = conv_count_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_word_q    <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      conv_count_q <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_word_q    <= s1_word_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      conv_count_q <= conv_count_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign conv_count = conv_count_q;

endmodule

// File: tb/tb_ieee_to_fp_11_9.sv
// Self-checking bench for ieee_to_fp_11_9: arithmetic reference model plus directed vectors.
module tb_ieee_to_fp_11_9;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [22:0] out_data;
  logic [15:0] conv_count;

  int unsigned total;
  int unsigned bad;

  logic [22:0] exp_q[$];
  logic        stall_prev;
  logic [22:0] held_data;
  logic [22:0] bp_held;
  logic [15:0] base_cnt;
  int          waits_sum;
  int          w;

`ifdef IEEE_SUBNORM_EN
  localparam logic [22:0] SUBNORM_ONE_EXP = 23'h26D400;
`else
  localparam logic [22:0] SUBNORM_ONE_EXP = 23'h000000;
`endif

  localparam int NV = 13;
  logic [31:0] vin  [NV] = '{32'h3F800000, 32'h80000000, 32'h7F800000, 32'h7FC00000,
                             32'h3F802000, 32'h3F806000, 32'h3FFFFFFF, 32'h00000001,
                             32'h7F7FFFFF, 32'h00800000, 32'hFFC00001, 32'hFF800000,
                             32'hBF800000};
  logic [22:0] vexp [NV] = '{23'h27FE00, 23'h100000, 23'h400000, 23'h600000,
                             23'h27FE00, 23'h27FE02, 23'h280000, SUBNORM_ONE_EXP,
                             23'h28FE00, 23'h270200, 23'h600000, 23'h500000,
                             23'h37FE00};

  ieee_to_fp_11_9 #(.WIDTH(22)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .conv_count (conv_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog act=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Reference: value-level decode, integer rounding, loop normalization.
  function automatic logic [22:0] model(input logic [31:0] x);
    int unsigned s, e, f, q, rem, oe;
    s = x[31]; e = x[30:23]; f = x[22:0]; oe = 0;
    if (e == 255) begin
      if (f == 0) return 23'(2 * 2**21 + s * 2**20);
      return 23'(3 * 2**21);
    end
    if (e == 0) begin
      if (f == 0) return 23'(s * 2**20);
`ifdef IEEE_SUBNORM_EN
      oe = 897;
      while (f < 2**23) begin
        f  = f * 2;
        oe = oe - 1;
      end
      f = f - 2**23;
`else
      return 23'(s * 2**20);
`endif
    end else begin
      oe = e + 896;
    end
    q   = f / 16384;
    rem = f % 16384;
    if (rem > 8192 || (rem == 8192 && (q % 2) == 1)) q = q + 1;
    if (q == 512) begin
      q  = 0;
      oe = oe + 1;
    end
    return 23'(2**21 + s * 2**20 + oe * 512 + q);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%h required=%h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'(out_data), 32'(held_data));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_out act=%h required=none", out_data);
        end else begin
          chk("stream_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_data));
      stall_prev = out_valid && !out_ready;
      held_data  = out_data;
    end
  end

  task automatic drive(input logic [31:0] x, output int waits);
    waits    = 0;
    in_valid = 1'b1;
    in_data  = x;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready) break;
      waits++;
    end
    chk("drive_accept", 32'(waits < 40), 32'd1);
    @(posedge clk); #2;
  endtask

  task automatic send_one(input logic [31:0] x, input logic [22:0] e);
    in_valid = 1'b1;
    in_data  = x;
    @(posedge clk); #2;
    in_valid = 1'b0;
    chk("lat_early_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #2;
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("lat_data", 32'(out_data), 32'(e));
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      @(posedge clk); #2;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    total = 0; bad = 0; stall_prev = 1'b0; held_data = '0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_conv_count", 32'(conv_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;

    for (int i = 0; i < NV; i++) chk("model_pin", 32'(model(vin[i])), 32'(vexp[i]));

    for (int i = 0; i < NV; i++) send_one(vin[i], vexp[i]);
    drain();

    // Full-rate stream: every word accepted on its first cycle.
    base_cnt  = conv_count;
    waits_sum = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(32'h3F000000 + 32'(i) * 32'h00013579, w);
      waits_sum += w;
    end
    in_valid = 1'b0;
    chk("tput_waits", 32'(waits_sum), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    chk("tput_count", 32'(16'(conv_count - base_cnt)), 32'd16);
    drain();

    // Backpressure: out_ready low for 3 cycles while 4 words stream.
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    out_ready = 1'b0;
    fork
      begin
        drive(32'h3F800000, w);
        drive(32'h40490FDB, w);
        drive(32'hC0000000, w);
        drive(32'h3F806000, w);
        in_valid = 1'b0;
      end
      begin
        repeat (2) @(posedge clk);
        #2;
        bp_held = out_data;
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_first", 32'(bp_held), 32'h0027FE00);
        for (int i = 0; i < 3; i++) begin
          @(posedge clk); #2;
          chk("bp_in_ready", 32'(in_ready), 32'd0);
          chk("bp_stable", 32'(out_data), 32'(bp_held));
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_count", 32'(conv_count), 32'd4);

    // Reset with two words in flight.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h40000000;
    @(posedge clk); #2;
    in_data   = 32'h40400000;
    @(posedge clk); #2;
    in_valid  = 1'b0;
    chk("rst_pre_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_count", 32'(conv_count), 32'd0);
    chk("rst_mid_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #2;
    rst = 1'b0;
    send_one(32'hC2F6E979, model(32'hC2F6E979));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      chk("post_rst_idle", 32'(out_valid), 32'd0);
    end
    chk("post_rst_count", 32'(conv_count), 32'd1);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
